uart_tx_fifo_drain: RTL
=======================

// Module: uart_tx_fifo_drain
// PURPOSE
// - UART transmitter on the read side of a sync_fifo TX buffer. Firmware writes bytes into the FIFO.
// - This block pops each byte and serialises it on tx_o as an asynchronous frame, LSB first.
// - Frame: 1 start bit, DATA_BITS data bits, optional parity bit, STOP_BITS stop bits.
// - Sits between the peripheral-bus TX FIFO and the chip UART pad.
// PARAMETERS
// - DATA_BITS  8    data bits per frame; range 5..8; equals the WIDTH of the paired FIFO.
// - CLK_DIV    868  clk_i cycles per bit time; must be >= 2 (868 = 100 MHz / 115200).
// - STOP_BITS  1    stop bits per frame; 1 or 2.
// PORTS
// - clk_i         in   1          system clock; all logic is on the rising edge.
// - rst_ni        in   1          asynchronous, active-low reset.
// - en_i          in   1          transmit enable; gates new pops only.
// - fifo_rdata_i  in   DATA_BITS  FIFO head word; valid combinationally whenever fifo_empty_i=0.
// - fifo_empty_i  in   1          FIFO empty flag.
// - fifo_re_o     out  1          FIFO pop strobe; one cycle per byte.
// - tx_o          out  1          serial line; idle high; driven from a register.
// - busy_o        out  1          1 while a frame is in flight; 0 only in IDLE.
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, tx_o=1, busy_o=0, fifo_re_o=0, all counters=0.
//   - Reset asserted mid-frame forces tx_o=1 immediately. The aborted byte is lost; no further pop.
// - Pop condition: pop = en_i & ~fifo_empty_i & (state==IDLE | last cycle of STOP).
//   - fifo_re_o = pop, combinational, high for exactly the pop cycle.
//   - fifo_re_o is never high while fifo_empty_i=1.
//   - On a pop, fifo_rdata_i is latched into shift_q in the same edge.
// - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//   - IDLE: tx_o=1. On pop -> START at the next edge.
//   - START: tx_o=0 for CLK_DIV cycles.
//   - DATA: tx_o=shift_q[0] per bit. shift_q shifts right after each CLK_DIV cycles.
//     - bit_cnt counts 0..DATA_BITS-1, then exits DATA.
//   - PARITY (UART_TX_PARITY_EN only): tx_o = even parity, i.e. XOR of the latched byte.
//     - Lasts CLK_DIV cycles.
//   - STOP: tx_o=1 for STOP_BITS*CLK_DIV cycles.
//     - If pop on its last cycle -> START directly (zero-gap back-to-back frames).
//     - Otherwise -> IDLE.
// - baud_cnt counts 0..CLK_DIV-1 and wraps at each bit boundary.
//   - Width is $clog2(CLK_DIV); it never exceeds CLK_DIV-1.
// - Latency: tx_o falls on the edge after the pop cycle.
//   - Frame length is exactly (1+DATA_BITS+P+STOP_BITS)*CLK_DIV cycles, P = 1 if parity enabled else 0.
// - en_i deasserted mid-frame: the current frame completes unchanged; no new pop while en_i=0.
// - FIFO refilled during a frame: no effect until the next pop point.
// - FIFO empty at the last STOP cycle: -> IDLE. A later write pops on the first cycle fifo_empty_i=0.
// - busy_o=1 from the edge after a pop until the edge entering IDLE.
// CONFIGURATION
// - UART_TX_PARITY_EN defined: PARITY state present; frames carry one even-parity bit after the data.
// - UART_TX_PARITY_EN undefined: PARITY state and logic absent; STOP directly follows the last data bit.
// TESTING (CLK_DIV=4, DATA_BITS=8, STOP_BITS=1 unless stated)
// 1. Reset, then hold FIFO empty with en_i=1 for 100 cycles -> tx_o=1, fifo_re_o=0, busy_o=0 throughout.
// 2. Push 0xA5 -> one-cycle fifo_re_o.
//    - tx_o shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total; busy_o then drops.
// 3. Push 0x00 and 0xFF back-to-back -> exactly 2 pops.
//    - Second start bit begins the cycle after the first stop bit ends; total 80 busy cycles.
// 4. Drop en_i during bit 3 of a frame with 2 bytes queued -> frame finishes; no second pop.
//    - Raising en_i again -> second frame starts.
// 5. Assert rst_ni low during DATA -> tx_o=1 asynchronously.
//    - After release: IDLE; the next queued byte is sent intact.
// 6. With UART_TX_PARITY_EN: send 0x07 -> parity bit 1, 44-cycle frame.
//    - Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a sync FIFO: pops one byte per frame and serialises it LSB first.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_drain #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CLK_DIV   = 868,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [DATA_BITS-1:0] fifo_rdata_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_re_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int unsigned BaudW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CntW  = $clog2(DATA_BITS);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]  DataLast = CntW'(DATA_BITS - 1);
    localparam logic [CntW-1:0]  StopLast = CntW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e               state_q;
    logic [BaudW-1:0]     baud_cnt_q;
    logic [CntW-1:0]      bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;
    logic                 busy_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic baud_last;
    logic stop_done;
    logic pop;

    assign baud_last = (baud_cnt_q == BaudLast);
    assign stop_done = (state_q == StStop) && baud_last && (bit_cnt_q == StopLast);
    // Reset gating keeps the FIFO untouched while the block is held in reset.
    assign pop       = rst_ni & en_i & ~fifo_empty_i & ((state_q == StIdle) | stop_done);

    assign fifo_re_o = pop;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;

    // tx_q is loaded with the level of the state being entered, so it changes on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state_q    <= StStart;
                        shift_q    <= fifo_rdata_i;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^fifo_rdata_i;
`endif
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= StData;
                        tx_q       <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == DataLast) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= StParity;
                            tx_q      <= parity_q;
`else
                            state_q   <= StStop;
                            tx_q      <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BaudW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= StStop;
                        tx_q       <= 1'b1;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BaudW'(1);
                    end
                end
`endif
                StStop: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == StopLast) begin
                            bit_cnt_q <= '0;
                            if (pop) begin
                                // Zero-gap back-to-back frame.
                                state_q  <= StStart;
                                shift_q  <= fifo_rdata_i;
                                tx_q     <= 1'b0;
                                busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                                parity_q <= ^fifo_rdata_i;
`endif
                            end else begin
                                state_q <= StIdle;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BaudW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_re_o |-> !fifo_empty_i);
    a_baud_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        baud_cnt_q <= BaudLast);
    a_idle_line_high: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StIdle) |-> (tx_q && !busy_q));
`endif

endmodule
